// File: rtl/ttt_pkg.sv
// Shared cell codes, FSM states, ASCII command/response bytes and win-line table
// for the tic-tac-toe board controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    MARK_X = 2'b01,
    MARK_O = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_CHECK = 3'd2,
    ST_RESP  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_DIGIT_1    = 8'h31;  // '1'
  localparam logic [7:0] CMD_DIGIT_9    = 8'h39;  // '9'
  localparam logic [7:0] CMD_RESTART    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RESTART_LC = 8'h72;  // 'r'

  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
  localparam logic [7:0] RSP_WIN_X   = 8'h58;  // 'X'
  localparam logic [7:0] RSP_WIN_O   = 8'h4F;  // 'O'
  localparam logic [7:0] RSP_DRAW    = 8'h44;  // 'D'
  localparam logic [7:0] RSP_RESTART = 8'h52;  // 'R'

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Rows, columns, then the two diagonals; cell index = row*3+col.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] c;
    c = EMPTY;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == 4'(i)) c = b[2*i +: 2];
    end
    return c;
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational three-in-a-row detector over the packed 18-bit board.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  output logic        win_x,
  output logic        win_o
);

  always_comb begin
    win_x = 1'b0;
    win_o = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (cell_of(board, WIN_LINES[l][0]) == MARK_X &&
          cell_of(board, WIN_LINES[l][1]) == MARK_X &&
          cell_of(board, WIN_LINES[l][2]) == MARK_X) win_x = 1'b1;
      if (cell_of(board, WIN_LINES[l][0]) == MARK_O &&
          cell_of(board, WIN_LINES[l][1]) == MARK_O &&
          cell_of(board, WIN_LINES[l][2]) == MARK_O) win_o = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe controller driven by UART command bytes; board at N+1, result at N+2.
// TTT_ECHO_EN adds the response byte path (RESP state holds tx until tx_ready).
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] START_PLAYER = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

`ifdef TTT_ECHO_EN
  localparam state_t ST_AFTER_RESTART = ST_RESP;
`else
  localparam state_t ST_AFTER_RESTART = ST_IDLE;
`endif

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [3:0]  moves_q, moves_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  cell_idx_q, cell_idx_d;
  logic        legal_q, legal_d;
`ifdef TTT_ECHO_EN
  logic [7:0]  resp_q, resp_d;
`else
  logic        unused_tx_ready;
  assign unused_tx_ready = tx_ready;
`endif

  logic win_x, win_o;
  logic rx_fire, is_digit, is_restart, mover_wins, is_draw;

  ttt_win_check u_win_check (
    .board (board_q),
    .win_x (win_x),
    .win_o (win_o)
  );

  assign rx_fire    = rx_valid && rx_ready;
  assign is_digit   = (rx_data >= CMD_DIGIT_1) && (rx_data <= CMD_DIGIT_9);
  assign is_restart = (rx_data == CMD_RESTART) || (rx_data == CMD_RESTART_LC);
  // Only a legal move can complete a line; win outranks draw on the ninth move.
  assign mover_wins = legal_q && (((turn_q == MARK_X) && win_x) || ((turn_q == MARK_O) && win_o));
  assign is_draw    = legal_q && !mover_wins && (moves_q == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire && is_digit)        state_d = ST_APPLY;
        else if (rx_fire && is_restart) state_d = ST_AFTER_RESTART;
      end
      ST_APPLY: state_d = ST_CHECK;
      ST_CHECK: begin
`ifdef TTT_ECHO_EN
        state_d = ST_RESP;
`else
        state_d = (mover_wins || is_draw) ? ST_OVER : ST_IDLE;
`endif
      end
`ifdef TTT_ECHO_EN
      ST_RESP: if (tx_ready) state_d = game_over_q ? ST_OVER : ST_IDLE;
`endif
      ST_OVER: if (rx_fire && is_restart) state_d = ST_AFTER_RESTART;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state_q == ST_IDLE) || (state_q == ST_OVER);
`ifdef TTT_ECHO_EN
    tx_valid = (state_q == ST_RESP);
    tx_data  = resp_q;
`else
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`endif
  end

  always_comb begin
    board_d     = board_q;
    turn_d      = turn_q;
    moves_d     = moves_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    cell_idx_d  = cell_idx_q;
    legal_d     = legal_q;
`ifdef TTT_ECHO_EN
    resp_d      = resp_q;
`endif
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (rx_fire && is_restart) begin
          board_d     = '0;
          turn_d      = START_PLAYER;
          moves_d     = '0;
          game_over_d = 1'b0;
          winner_d    = EMPTY;
`ifdef TTT_ECHO_EN
          resp_d      = RSP_RESTART;
`endif
        end else if (rx_fire && is_digit && (state_q == ST_IDLE)) begin
          // '1'..'9' carry the cell number in the low nibble.
          cell_idx_d = rx_data[3:0] - 4'd1;
        end
      end
      ST_APPLY: begin
        legal_d = (cell_of(board_q, cell_idx_q) == EMPTY);
        if (legal_d) begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_idx_q == 4'(i)) board_d[2*i +: 2] = turn_q;
          end
          moves_d = moves_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mover_wins) begin
          game_over_d = 1'b1;
          winner_d    = turn_q;
`ifdef TTT_ECHO_EN
          resp_d      = (turn_q == MARK_X) ? RSP_WIN_X : RSP_WIN_O;
`endif
        end else if (is_draw) begin
          game_over_d = 1'b1;
          winner_d    = EMPTY;
`ifdef TTT_ECHO_EN
          resp_d      = RSP_DRAW;
`endif
        end else if (legal_q) begin
          turn_d = (turn_q == MARK_X) ? MARK_O : MARK_X;
`ifdef TTT_ECHO_EN
          resp_d = RSP_OK;
`endif
        end else begin
`ifdef TTT_ECHO_EN
          resp_d = RSP_ERR;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q     <= '0;
      turn_q      <= START_PLAYER;
      moves_q     <= '0;
      game_over_q <= 1'b0;
      winner_q    <= EMPTY;
      cell_idx_q  <= '0;
      legal_q     <= 1'b0;
`ifdef TTT_ECHO_EN
      resp_q      <= 8'h00;
`endif
    end else begin
      board_q     <= board_d;
      turn_q      <= turn_d;
      moves_q     <= moves_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      cell_idx_q  <= cell_idx_d;
      legal_q     <= legal_d;
`ifdef TTT_ECHO_EN
      resp_q      <= resp_d;
`endif
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Self-checking bench for ttt_board_ctrl; adapts to TTT_ECHO_EN.
module tb_ttt_board_ctrl;

  localparam logic [1:0] PX = 2'b01;
  localparam logic [1:0] PO = 2'b10;

  logic        clk, reset, rx_valid, rx_ready, game_over, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic [17:0] board;
  logic [1:0]  turn, winner;
  int          tests, fails;

  ttt_board_ctrl #(.START_PLAYER(2'b01)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .board     (board),
    .turn      (turn),
    .game_over (game_over),
    .winner    (winner),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;
    string      brd;
    logic [1:0] trn;
    logic       go;
    logic [1:0] win;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic void add(input logic [7:0] rx, input string brd, input logic [1:0] trn,
                              input logic go, input logic [1:0] win, input logic [7:0] tx);
    vec_t v;
    v.rx = rx; v.brd = brd; v.trn = trn; v.go = go; v.win = win; v.tx = tx;
    vecs.push_back(v);
  endfunction

  function automatic logic [17:0] bd(input string s);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (s[i] == "X") r[2*i +: 2] = PX;
      else if (s[i] == "O") r[2*i +: 2] = PO;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns just after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v, e;
    logic [17:0] pb;
    logic [1:0]  pt;
    logic        rst_cmd;

    tests = 0; fails = 0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    // Game A: first move, illegal repeat, restart
    add("5", "....X....", PO, 1'b0, 2'b00, "K");
    add("5", "....X....", PO, 1'b0, 2'b00, "E");
    add("R", ".........", PX, 1'b0, 2'b00, "R");
    // Game B: X wins top row, later digit ignored
    add("1", "X........", PO, 1'b0, 2'b00, "K");
    add("4", "X..O.....", PX, 1'b0, 2'b00, "K");
    add("2", "XX.O.....", PO, 1'b0, 2'b00, "K");
    add("5", "XX.OO....", PX, 1'b0, 2'b00, "K");
    add("3", "XXXOO....", PX, 1'b1, PX,    "X");
    add("9", "XXXOO....", PX, 1'b1, PX,    8'h00);
    add("r", ".........", PX, 1'b0, 2'b00, "R");
    // Game C: full board draw, restart, junk byte
    add("1", "X........", PO, 1'b0, 2'b00, "K");
    add("2", "XO.......", PX, 1'b0, 2'b00, "K");
    add("3", "XOX......", PO, 1'b0, 2'b00, "K");
    add("5", "XOX.O....", PX, 1'b0, 2'b00, "K");
    add("4", "XOXXO....", PO, 1'b0, 2'b00, "K");
    add("6", "XOXXOO...", PX, 1'b0, 2'b00, "K");
    add("8", "XOXXOO.X.", PO, 1'b0, 2'b00, "K");
    add("7", "XOXXOOOX.", PX, 1'b0, 2'b00, "K");
    add("9", "XOXXOOOXX", PX, 1'b1, 2'b00, "D");
    add("R", ".........", PX, 1'b0, 2'b00, "R");
    add("A", ".........", PX, 1'b0, 2'b00, 8'h00);
    // Game D: X wins on the ninth move (win beats draw)
    add("1", "X........", PO, 1'b0, 2'b00, "K");
    add("2", "XO.......", PX, 1'b0, 2'b00, "K");
    add("3", "XOX......", PO, 1'b0, 2'b00, "K");
    add("4", "XOXO.....", PX, 1'b0, 2'b00, "K");
    add("5", "XOXOX....", PO, 1'b0, 2'b00, "K");
    add("6", "XOXOXO...", PX, 1'b0, 2'b00, "K");
    add("8", "XOXOXO.X.", PO, 1'b0, 2'b00, "K");
    add("7", "XOXOXOOX.", PX, 1'b0, 2'b00, "K");
    add("9", "XOXOXOOXX", PX, 1'b1, PX,    "X");
    add("R", ".........", PX, 1'b0, 2'b00, "R");
    // Game E: O wins middle row
    add("1", "X........", PO, 1'b0, 2'b00, "K");
    add("4", "X..O.....", PX, 1'b0, 2'b00, "K");
    add("2", "XX.O.....", PO, 1'b0, 2'b00, "K");
    add("5", "XX.OO....", PX, 1'b0, 2'b00, "K");
    add("9", "XX.OO...X", PO, 1'b0, 2'b00, "K");
    add("6", "XX.OOO..X", PO, 1'b1, PO,    "O");
    add("R", ".........", PX, 1'b0, 2'b00, "R");

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_board",    32'(board),     32'd0);
    check("rst_turn",     32'(turn),      32'(PX));
    check("rst_game_over",32'(game_over), 32'd0);
    check("rst_winner",   32'(winner),    32'd0);
    check("rst_tx_valid", 32'(tx_valid),  32'd0);
    check("rst_tx_data",  32'(tx_data),   32'd0);
    check("rst_rx_ready", 32'(rx_ready),  32'd1);

    pb = '0;
    pt = PX;
    foreach (vecs[k]) begin
      v = vecs[k];
      rst_cmd = (v.rx == "R") || (v.rx == "r");
      send_byte(v.rx);
      sb.push_back(v);
      @(negedge clk);
      if (!rst_cmd) check($sformatf("v%0d_board_N", k), 32'(board), 32'(pb));
      @(negedge clk);
      check($sformatf("v%0d_board_N1", k), 32'(board), 32'(bd(v.brd)));
      if (!rst_cmd) check($sformatf("v%0d_turn_N1", k), 32'(turn), 32'(pt));
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_turn", k),      32'(turn),      32'(e.trn));
      check($sformatf("v%0d_game_over", k), 32'(game_over), 32'(e.go));
      check($sformatf("v%0d_winner", k),    32'(winner),    32'(e.win));
`ifdef TTT_ECHO_EN
      if (e.tx != 8'h00) begin
        check($sformatf("v%0d_tx_valid", k), 32'(tx_valid), 32'd1);
        check($sformatf("v%0d_tx_data", k),  32'(tx_data),  32'(e.tx));
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_tx_done", k), 32'(tx_valid), 32'd0);
      end else begin
        check($sformatf("v%0d_no_tx", k), 32'(tx_valid), 32'd0);
      end
`else
      check($sformatf("v%0d_tx_valid", k), 32'(tx_valid), 32'd0);
      check($sformatf("v%0d_tx_data", k),  32'(tx_data),  32'd0);
`endif
      pb = bd(e.brd);
      pt = e.trn;
    end

    // Byte offered while busy is dropped; with echo, tx held under backpressure.
    send_byte("1");
    @(negedge clk);
    check("busy_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b1;
    rx_data  = "2";
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
`ifdef TTT_ECHO_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = (i == 3);
      rx_data  = "3";
      check($sformatf("bp%0d_tx_valid", i), 32'(tx_valid), 32'd1);
      check($sformatf("bp%0d_tx_data", i),  32'(tx_data),  32'(8'h4B));
      check($sformatf("bp%0d_rx_ready", i), 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
`endif
    @(negedge clk);
    check("drop_tx_valid", 32'(tx_valid), 32'd0);
    check("drop_rx_ready", 32'(rx_ready), 32'd1);
    check("drop_board",    32'(board),    32'(bd("X........")));
    check("drop_turn",     32'(turn),     32'(PO));

    // Reset mid-operation (pending response with echo) aborts everything.
    send_byte("5");
    @(negedge clk);
`ifdef TTT_ECHO_EN
    repeat (2) @(negedge clk);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
`endif
    reset = 1'b1; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = "1";
    @(negedge clk);
    reset = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    check("mid_rst_tx_valid",  32'(tx_valid),  32'd0);
    check("mid_rst_tx_data",   32'(tx_data),   32'd0);
    check("mid_rst_board",     32'(board),     32'd0);
    check("mid_rst_turn",      32'(turn),      32'(PX));
    check("mid_rst_game_over", 32'(game_over), 32'd0);
    check("mid_rst_rx_ready",  32'(rx_ready),  32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
